// File: rtl/i2s_audio_transmitter.sv
// i2s_audio_transmitter
//   Buffers mono 16-bit samples in a small FIFO and serialises them as a
//   stereo I2S stream. Each sample is sent as both the left and the right word.
//   The stream is MSB first, uses the standard one-bit delay, and has 32 bclk
//   slots per frame.
//
// Parameters
//   FIFO_DEPTH  sample buffer depth in words (power of two, 4..256)
//   BCLK_HALF   clk cycles per i2s_bclk half-period (>= 2)
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   audio_in      signed mono sample, qualified by sample_valid
//   sample_valid  one-cycle write strobe; there is no backpressure
//   flag_clr      clears the sticky flags; a new error event in the same cycle wins
//   i2s_bclk      bit clock
//   i2s_lrclk     word select (0 = left, 1 = right)
//   i2s_sdata     serial data
//   fifo_level    number of buffered words
//   overflow      sticky: a sample was dropped because the FIFO was full
//   underflow     sticky: a frame started while the FIFO was empty
//
// Configuration macro
//   I2S_UNDERRUN_HOLD_EN  when defined, an underrun repeats the last popped
//                         word; otherwise an underrun sends silence (16'h0000).

module i2s_audio_transmitter #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BCLK_HALF  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   audio_in,
  input  logic                          sample_valid,
  input  logic                          flag_clr,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic [DW-1:0] DivLast  = DW'(BCLK_HALF - 1);
  localparam logic [DW-1:0] DivOne   = DW'(1);
  localparam logic [AW:0]   CntFull  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  // Sample storage
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Bit clock and frame state
  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [4:0]    slot_q, slot_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic [15:0]   word_q, word_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          div_end, bclk_fall, frame_start;
  logic          fifo_empty, fifo_full;
  logic          pop_ok, push_ok, ovf_set, unf_set;
  logic [4:0]    slot_next;
  logic [3:0]    bit_idx;
  logic [15:0]   fallback_word;

`ifdef I2S_UNDERRUN_HOLD_EN
  // word_q always holds the last successfully popped word (0 after reset).
  assign fallback_word = word_q;
`else
  assign fallback_word = 16'h0000;
`endif

  always_comb begin
    div_end     = (div_q == DivLast);
    bclk_fall   = div_end && bclk_q;
    slot_next   = slot_q + 5'd1;
    frame_start = bclk_fall && (slot_q == 5'd31);

    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CntFull);
    pop_ok      = frame_start && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    push_ok     = sample_valid && (!fifo_full || pop_ok);
    ovf_set     = sample_valid && fifo_full && !pop_ok;
    unf_set     = frame_start && fifo_empty;

    // Slot k carries bit (16-k) mod 16. Slot 0 takes bit 0 of the outgoing
    // word because word_q is reloaded at the same edge.
    bit_idx     = 4'd0 - slot_next[3:0];

    div_d    = div_end ? '0 : div_q + DivOne;
    bclk_d   = div_end ? !bclk_q : bclk_q;
    slot_d   = slot_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    word_d   = word_q;
    if (bclk_fall) begin
      slot_d  = slot_next;
      lrclk_d = slot_next[4];
      sdata_d = word_q[bit_idx];
    end
    if (frame_start) begin
      word_d = pop_ok ? mem[rd_ptr_q] : fallback_word;
    end

    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // Set wins over clear.
    ovf_d = (ovf_q && !flag_clr) || ovf_set;
    unf_d = (unf_q && !flag_clr) || unf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      slot_q   <= '0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      slot_q   <= slot_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      word_q   <= word_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_q] <= audio_in;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// Bench for i2s_audio_transmitter (default parameters: depth 16, bclk half 8).
// A reference model built from edge counts and a sample queue predicts every
// output cycle by cycle. Table-driven frame captures and hand-written
// sequences cover the corner cases.
module tb_i2s_audio_transmitter;

  localparam int H     = 8;
  localparam int D     = 16;
  localparam int FRAME = 64 * H;

  logic        clk = 1'b0;
  logic        rst, sample_valid, flag_clr;
  logic [15:0] audio_in;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  i2s_audio_transmitter #(.FIFO_DEPTH(D), .BCLK_HALF(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_in     (audio_in),
    .sample_valid (sample_valid),
    .flag_clr     (flag_clr),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int cmp = 0;
  int bad = 0;

  // Reference model state
  int          n;
  logic [15:0] q[$];
  logic [15:0] cur, prev, last;
  bit          m_ovf, m_unf, m_fall, m_start;

  function automatic logic exp_sdata(int s);
    if (s == 0)       return prev[0];
    else if (s <= 16) return cur[16 - s];
    else              return cur[32 - s];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(bit r, bit v, logic [15:0] d, bit c);
    bit ovs, uns, e_bclk, e_lr, e_sd;
    int slot;
    @(negedge clk);
    rst = r; sample_valid = v; audio_in = d; flag_clr = c;
    @(posedge clk);
    m_fall = 0; m_start = 0; ovs = 0; uns = 0;
    if (r) begin
      n = 0; q.delete(); cur = 0; prev = 0; last = 0; m_ovf = 0; m_unf = 0;
    end else begin
      n++;
      if (n % (2 * H) == 0) begin
        m_fall = 1;
        if ((n / (2 * H)) % 32 == 0) begin
          m_start = 1;
          prev = cur;
          if (q.size() > 0) begin
            cur = q.pop_front();
            last = cur;
          end else begin
            uns = 1;
`ifdef I2S_UNDERRUN_HOLD_EN
            cur = last;
`else
            cur = 16'h0000;
`endif
          end
        end
      end
      if (v) begin
        if (q.size() < D) q.push_back(d);
        else ovs = 1;
      end
      m_ovf = (m_ovf && !c) || ovs;
      m_unf = (m_unf && !c) || uns;
    end
    slot   = (n / (2 * H)) % 32;
    e_bclk = ((n / H) % 2) == 1;
    e_lr   = slot >= 16;
    e_sd   = exp_sdata(slot);
    #1;
    cmp++;
    if (i2s_bclk !== e_bclk || i2s_lrclk !== e_lr || i2s_sdata !== e_sd ||
        int'(fifo_level) != q.size() || overflow !== m_ovf || underflow !== m_unf) begin
      bad++;
      $display("FAIL model n=%0d bclk/lr/sd/lvl/ovf/unf got %b %b %b %0d %b %b expected %b %b %b %0d %b %b",
               n, i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, overflow, underflow,
               e_bclk, e_lr, e_sd, q.size(), m_ovf, m_unf);
    end
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
  endtask

  task automatic wait_frame_start();
    int k;
    k = 0;
    m_start = 0;
    while (!m_start && k < FRAME + 4) begin
      idle();
      k++;
    end
    check("frame_start_seen", 32'(m_start), 32'd1);
  endtask

  // Records the next 32 bclk falling edges (slots 1..31 then slot 0).
  task automatic capture32(output logic [31:0] s, output logic [31:0] lr);
    int got, k;
    got = 0; k = 0; s = '0; lr = '0;
    while (got < 32 && k < FRAME + 4 * H) begin
      idle();
      k++;
      if (m_fall) begin
        s  = {s[30:0], i2s_sdata};
        lr = {lr[30:0], i2s_lrclk};
        got++;
      end
    end
    check("capture_complete", 32'(got), 32'd32);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [31:0] exp_s;
    logic [31:0] exp_lr;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] s, lr, exp2;
  int          k, rate;
  bit          rr, vv, cc;

  initial begin
    vecs[0] = '{w: 16'hA5C3, exp_s: 32'hA5C3A5C3, exp_lr: 32'h0001FFFE};
    vecs[1] = '{w: 16'h7FFF, exp_s: 32'h7FFF7FFF, exp_lr: 32'h0001FFFE};
    vecs[2] = '{w: 16'h8001, exp_s: 32'h80018001, exp_lr: 32'h0001FFFE};
    vecs[3] = '{w: 16'h1234, exp_s: 32'h12341234, exp_lr: 32'h0001FFFE};

    rst = 1; sample_valid = 0; audio_in = 0; flag_clr = 0;
    do_reset();
    check("reset_outputs",
          {26'd0, i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, 1'b0} |
          32'(fifo_level), 32'd0);

    // One word per run, then drain: the word is sent once, then the underrun fallback.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      step(0, 1, vecs[i].w, 0);
      wait_frame_start();
      capture32(s, lr);
      check("frame_data", s, vecs[i].exp_s);
      check("frame_lrclk", lr, vecs[i].exp_lr);
      check("underflow_after_drain", 32'(underflow), 32'd1);
      check("level_after_drain", 32'(fifo_level), 32'd0);
`ifdef I2S_UNDERRUN_HOLD_EN
      exp2 = {vecs[i].w, vecs[i].w};
`else
      exp2 = 32'h0;
`endif
      capture32(s, lr);
      check("underrun_frame_data", s, exp2);
    end

    // 17 pushes into a 16-deep FIFO: the 17th is dropped and never sent.
    do_reset();
    for (int i = 1; i <= 17; i++) step(0, 1, 16'(i * 16'h0101), 0);
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int f = 0; f < 16; f++) wait_frame_start();
    check("drain16_level", 32'(fifo_level), 32'd0);
    check("drain16_no_underflow", 32'(underflow), 32'd0);
    wait_frame_start();
    check("drain17_underflow", 32'(underflow), 32'd1);

    // Push on the exact cycle of the slot-0 pop while full.
    do_reset();
    for (int i = 1; i <= 16; i++) step(0, 1, 16'(100 + i), 0);
    check("full_level", 32'(fifo_level), 32'd16);
    k = 0;
    while (((n + 1) % FRAME) != 0 && k < FRAME) begin
      idle();
      k++;
    end
    step(0, 1, 16'hBEEF, 0);
    check("pushpop_was_frame_start", 32'(m_start), 32'd1);
    check("pushpop_level", 32'(fifo_level), 32'd16);
    check("pushpop_no_ovf", 32'(overflow), 32'd0);

    // Clear coincident with a drop: set wins; a lone clear then clears.
    step(0, 1, 16'h1111, 1);
    check("clr_with_drop", 32'(overflow), 32'd1);
    step(0, 0, 16'h0, 1);
    check("clr_alone", 32'(overflow), 32'd0);

    // Reset mid-frame at slot 20.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 16'(16'h0F00 + i), 0);
    k = 0;
    while (((n / (2 * H)) % 32) != 20 && k < 2 * FRAME) begin
      idle();
      k++;
    end
    check("slot20_reached", 32'(i2s_lrclk), 32'd1);
    check("slot20_level", 32'(fifo_level), 32'd5);
    step(1, 0, 16'h0, 0);
    check("midframe_reset",
          {26'd0, i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, 1'b0} |
          32'(fifo_level), 32'd0);
    k = 0;
    do begin
      idle();
      k++;
    end while (!i2s_bclk && k < 4 * H);
    check("first_bclk_rise", 32'(k), 32'd8);

    // Randomized traffic with varying push rates, clears and occasional resets.
    do_reset();
    for (int e = 0; e < 10; e++) begin
      case (e % 3)
        0:       rate = 30;
        1:       rate = 300;
        default: rate = 3000;
      endcase
      for (int c = 0; c < 2000; c++) begin
        vv = ($urandom_range(0, rate - 1) == 0);
        cc = ($urandom_range(0, 399) == 0);
        rr = ($urandom_range(0, 4999) == 0);
        step(rr, vv, 16'($urandom), cc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/i2s_audio_transmitter.md
I2S_AUDIO_TRANSMITTER -- requirements
Module: i2s_audio_transmitter

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the sample buffer depth in words (power of two, 4..256).
REQ-003 Parameter BCLK_HALF, default 8, SHALL set the number of clk cycles per i2s_bclk half-period (>=2).
REQ-004 Port clk, input, 1, SHALL be the system clock.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port audio_in, input, 16, SHALL carry the signed mono sample from the synthesizer.
REQ-007 Port sample_valid, input, 1, SHALL qualify audio_in for one clk cycle per sample.
REQ-008 Port flag_clr, input, 1, SHALL clear the sticky flags when high.
REQ-009 Port i2s_bclk, output, 1, SHALL be the I2S bit clock.
REQ-010 Port i2s_lrclk, output, 1, SHALL be word select: 0 = left, 1 = right.
REQ-011 Port i2s_sdata, output, 1, SHALL be serial data, MSB first.
REQ-012 Port fifo_level, output, $clog2(FIFO_DEPTH)+1, SHALL report the stored word count.
REQ-013 Port overflow, output, 1, and port underflow, output, 1, SHALL be sticky error flags.

Function
REQ-014 A write SHALL occur on each clk edge with sample_valid=1 and fifo_level<FIFO_DEPTH; there is no backpressure.
REQ-015 sample_valid=1 at fifo_level=FIFO_DEPTH with no same-cycle pop SHALL drop the sample and set overflow.
REQ-016 Same-cycle push and pop SHALL both take effect, leave fifo_level unchanged, and never set overflow, including when full.
REQ-017 A free-running divider SHALL toggle i2s_bclk every BCLK_HALF clk cycles; the first rising edge SHALL come BCLK_HALF cycles after rst deasserts.
REQ-018 A 5-bit slot counter SHALL advance on each bclk falling edge (0..31, wrapping 31->0); all outputs SHALL change only on bclk falling edges.
REQ-019 i2s_lrclk SHALL be 0 in slots 0..15 and 1 in slots 16..31.
REQ-020 On entry to slot 0, the block SHALL pop one FIFO word W and load it as both the left and right words of the frame (mono duplicated).
REQ-021 i2s_sdata SHALL carry left bit 15-(k-1) in slots k=1..16, right bit 15-(k-17) in slots 17..31, and right bit 0 of the previous frame in slot 0 (I2S one-bit delay).
REQ-022 A pop on an empty FIFO SHALL set underflow and load the fallback word defined in REQ-026/027.
REQ-023 Fill and drain SHALL wrap through read/write pointers modulo FIFO_DEPTH with no loss.
REQ-024 flag_clr coincident with a new error event SHALL leave the flag set (set wins).

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL drive: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, fifo_level=0, overflow=0, underflow=0. It SHALL also reset the divider and slot counter to 0, set the held word to 0, and empty the FIFO. Reset mid-frame SHALL abort the frame immediately.

Configuration
REQ-026 With macro I2S_UNDERRUN_HOLD_EN defined, the underflow fallback word SHALL be the last word successfully popped (0 if none since reset).
REQ-027 Without I2S_UNDERRUN_HOLD_EN, the underflow fallback word SHALL be 16'h0000.

Verification
REQ-028 Push 16'hA5C3, then let the FIFO drain -> the next frame carries A5C3 MSB-first in slots 1..16 and 17..31+0 (right channel), and lrclk toggles at slots 0 and 16.
REQ-029 With BCLK_HALF=8, push 17 samples with no frame in progress -> fifo_level=16, overflow=1, and the 17th sample is absent from the output.
REQ-030 Keep the FIFO empty across a frame start -> underflow=1, and the frame carries 0000 (no macro) or the previously popped 7FFF (with I2S_UNDERRUN_HOLD_EN).
REQ-031 With fifo_level=16, assert sample_valid on the exact cycle of the slot-0 pop -> fifo_level stays 16 and overflow stays 0.
REQ-032 Assert rst at slot 20 with fifo_level=5 -> the next cycle shows all outputs 0 and fifo_level=0, and the first bclk rise occurs 8 cycles after release.
REQ-033 Assert flag_clr in the same cycle as an overflow drop -> overflow remains 1; assert flag_clr alone next cycle -> overflow=0.
